// File: rtl/axi_full_mem_slave.sv
// AXI4 INCR/FIXED burst memory responder: R beat 1 cycle after AR, B 1 cycle after WLAST; one burst per channel.
// Holds R/B until RREADY/BREADY; `AXI_MEM_STALL_EN adds LFSR-driven WREADY/RVALID gaps.
module axi_full_mem_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_MEM_DEPTH_LOG2   = 10
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);
  localparam int N  = C_MEM_DEPTH_LOG2;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int IW = C_S_AXI_ID_WIDTH;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  localparam logic [N-1:0] IDX_ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [DW-1:0] mem [0:(1<<N)-1];
  logic          stall_nxt;
  logic          unused_addr;
  assign unused_addr = ^{S_AXI_AWADDR, S_AXI_ARADDR};

`ifdef AXI_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) lfsr_q <= 16'hACE1;
    else                lfsr_q <= lfsr_d;
  // Ready/valid are registered, so gate them with the LFSR value they will coincide with.
  assign stall_nxt = lfsr_d[0];
`else
  assign stall_nxt = 1'b0;
`endif

  // ---------------- write channel ----------------
  w_state_e      w_state_q, w_state_d;
  logic [IW-1:0] w_id_q, w_id_d;
  logic [N-1:0]  w_idx_q, w_idx_d;
  logic [7:0]    w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic          w_fixed_q, w_fixed_d, w_err_q, w_err_d, w_over_q, w_over_d;
  logic          awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          mem_we;

  always_comb begin
    w_state_d = w_state_q;  w_id_d   = w_id_q;   w_idx_d  = w_idx_q;
    w_len_d   = w_len_q;    w_beat_d = w_beat_q; w_fixed_d = w_fixed_q;
    w_err_d   = w_err_q;    w_over_d = w_over_q; bvalid_d = bvalid_q;
    bresp_d   = bresp_q;    mem_we   = 1'b0;
    case (w_state_q)
      W_IDLE: if (S_AXI_AWVALID && awready_q) begin
        w_id_d    = S_AXI_AWID;
        w_idx_d   = S_AXI_AWADDR[N+1:2];
        w_len_d   = S_AXI_AWLEN;
        w_fixed_d = (S_AXI_AWBURST == 2'b00);
        w_err_d   = (S_AXI_AWSIZE != 3'b010) || S_AXI_AWBURST[1];
        w_beat_d  = 8'd0;
        w_over_d  = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (S_AXI_WVALID && wready_q) begin
        mem_we = !w_err_q && !w_over_q;
        if (!w_fixed_q) w_idx_d = w_idx_q + IDX_ONE;
        // Counter saturates at LEN; further beats only raise the overrun flag.
        if (w_beat_q == w_len_q) w_over_d = w_over_q || !S_AXI_WLAST;
        else                     w_beat_d = w_beat_q + 8'd1;
        if (S_AXI_WLAST) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = (w_err_q || w_over_q || (w_beat_q != w_len_q)) ? SLVERR : OKAY;
        end
      end
      W_RESP: if (S_AXI_BREADY) begin
        bvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA) && !stall_nxt;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE; w_id_q <= '0; w_idx_q <= '0; w_len_q <= '0; w_beat_q <= '0;
      w_fixed_q <= 1'b0; w_err_q <= 1'b0; w_over_q <= 1'b0;
      awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0; bresp_q <= OKAY;
    end else begin
      w_state_q <= w_state_d; w_id_q <= w_id_d; w_idx_q <= w_idx_d; w_len_q <= w_len_d;
      w_beat_q <= w_beat_d; w_fixed_q <= w_fixed_d; w_err_q <= w_err_d; w_over_q <= w_over_d;
      awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d; bresp_q <= bresp_d;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we)
      for (int b = 0; b < DW/8; b++)
        if (S_AXI_WSTRB[b]) mem[w_idx_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
  end

  // ---------------- read channel ----------------
  r_state_e      r_state_q, r_state_d;
  logic [IW-1:0] r_id_q, r_id_d;
  logic [N-1:0]  r_idx_q, r_idx_d;
  logic [7:0]    r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic          r_fixed_q, r_fixed_d, r_err_q, r_err_d;
  logic          arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          load_beat;

  always_comb begin
    r_state_d = r_state_q; r_id_d   = r_id_q;   r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;   r_beat_d = r_beat_q; r_fixed_d = r_fixed_q;
    r_err_d   = r_err_q;   rvalid_d = rvalid_q; rlast_d   = rlast_q;
    rdata_d   = rdata_q;   rresp_d  = rresp_q;  load_beat = 1'b0;
    case (r_state_q)
      R_IDLE: if (S_AXI_ARVALID && arready_q) begin
        r_id_d    = S_AXI_ARID;
        r_idx_d   = S_AXI_ARADDR[N+1:2];
        r_len_d   = S_AXI_ARLEN;
        r_fixed_d = (S_AXI_ARBURST == 2'b00);
        r_err_d   = (S_AXI_ARSIZE != 3'b010) || S_AXI_ARBURST[1];
        r_beat_d  = 8'd0;
        r_state_d = R_DATA;
        load_beat = 1'b1;
      end
      R_DATA: begin
        if (rvalid_q && S_AXI_RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            if (!r_fixed_q) r_idx_d = r_idx_q + IDX_ONE;
            r_beat_d  = r_beat_q + 8'd1;
            load_beat = 1'b1;
          end
        end else if (!rvalid_q) begin
          load_beat = 1'b1;  // beat withheld by a stall cycle
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (load_beat) begin
      rvalid_d = !stall_nxt;
      rdata_d  = r_err_d ? '0 : mem[r_idx_d];
      rlast_d  = (r_beat_d == r_len_d);
      rresp_d  = r_err_d ? SLVERR : OKAY;
    end
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_q <= R_IDLE; r_id_q <= '0; r_idx_q <= '0; r_len_q <= '0; r_beat_q <= '0;
      r_fixed_q <= 1'b0; r_err_q <= 1'b0; arready_q <= 1'b0; rvalid_q <= 1'b0;
      rlast_q <= 1'b0; rdata_q <= '0; rresp_q <= OKAY;
    end else begin
      r_state_q <= r_state_d; r_id_q <= r_id_d; r_idx_q <= r_idx_d; r_len_q <= r_len_d;
      r_beat_q <= r_beat_d; r_fixed_q <= r_fixed_d; r_err_q <= r_err_d; arready_q <= arready_d;
      rvalid_q <= rvalid_d; rlast_q <= rlast_d; rdata_q <= rdata_d; rresp_q <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BID     = w_id_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RID     = r_id_q;
endmodule

// File: tb/tb_axi_full_mem_slave.sv
// Directed bench for axi_full_mem_slave: single-beat vector table plus burst, wrap, error, stall and reset sequences.
module tb_axi_full_mem_slave;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [0:0]  awid = '0, bid, arid = '0, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rlast, rvalid, rready = 0;

  int checks = 0;
  int errors = 0;

  logic [31:0] rdat [0:255];
  logic        rlst [0:255];
  logic [1:0]  rrsp [0:255];

  always #5 clk = ~clk;

  axi_full_mem_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(arst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                          input int nbeats, output logic [1:0] resp);
    int t;
    awid = 1'b1; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) timeout("aw_ready");
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = base + 32'(i); wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1'b1;
      t = 0;
      while (!wready && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) timeout("w_ready");
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) timeout("b_valid");
    resp = bresp;
    chk("bid", 32'(bid), 32'd1);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input bit toggle, output int n);
    int t, cyc;
    bit held, done;
    logic [31:0] hd;
    logic hl;
    arid = 1'b1; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) timeout("ar_ready");
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0; cyc = 0; held = 0; done = 0; t = 0; hd = '0; hl = 1'b0;
    while (!done && t < 400) begin
      rready = toggle ? (cyc[0] == 1'b0) : 1'b1;
      if (held) begin
        chk("r_hold_valid", 32'(rvalid), 32'd1);
        chk("r_hold_data", rdata, hd);
        chk("r_hold_last", 32'(rlast), 32'(hl));
      end
      held = 0;
      if (rvalid) begin
        if (rready) begin
          rdat[n] = rdata; rlst[n] = rlast; rrsp[n] = rresp;
          chk("rid", 32'(rid), 32'd1);
          n++;
          if (rlast || n == 256) done = 1;
        end else begin
          held = 1; hd = rdata; hl = rlast;
        end
      end
      @(posedge clk); #1;
      cyc++; t++;
    end
    rready = 1'b0;
    if (!done) timeout("r_last");
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic check_burst(input string name, input int n, input int exp_n,
                             input logic [31:0] exp_d [0:15], input logic [1:0] exp_r);
    chk({name, "_beats"}, 32'(n), 32'(exp_n));
    for (int i = 0; i < exp_n && i < n; i++) begin
      chk({name, "_data"}, rdat[i], exp_d[i]);
      chk({name, "_last"}, 32'(rlst[i]), 32'(i == exp_n - 1));
      chk({name, "_resp"}, 32'(rrsp[i]), 32'(exp_r));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp, resp2;
    int          n;
    logic [31:0] exp [0:15];

    vecs[0]  = '{1'b1, 32'h0000_0014, 3'b010, 2'b01, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0014, 3'b010, 2'b01, 32'h0000_0000, 4'h5, 2'b00, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0014, 3'b010, 2'b01, 32'h0,         4'h0, 2'b00, 32'hFF00_FF00};
    vecs[3]  = '{1'b1, 32'h4000_0020, 3'b010, 2'b00, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0020, 3'b010, 2'b01, 32'h1234_5678, 4'h8, 2'b00, 32'h0};
    vecs[5]  = '{1'b0, 32'h8000_0020, 3'b010, 2'b01, 32'h0,         4'h0, 2'b00, 32'h12A5_A5A5};
    vecs[6]  = '{1'b1, 32'h0000_0020, 3'b001, 2'b01, 32'h0,         4'hF, 2'b10, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0020, 3'b010, 2'b01, 32'h0,         4'h0, 2'b00, 32'h12A5_A5A5};
    vecs[8]  = '{1'b0, 32'h0000_0020, 3'b001, 2'b01, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0020, 3'b010, 2'b11, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_0020, 3'b010, 2'b10, 32'h0,         4'hF, 2'b10, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0020, 3'b010, 2'b00, 32'h0,         4'h0, 2'b00, 32'h12A5_A5A5};

    // Reset state, then ready rises on the first edge after release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_valids", {29'd0, wready, bvalid, rvalid}, 32'd0);
    arst_n = 1'b1;
    #1 chk("rel_awready_pre", 32'(awready), 32'd0);
    @(posedge clk); #1;
    chk("rel_awready", 32'(awready), 32'd1);
    chk("rel_arready", 32'(arready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, 8'd0, vecs[i].size, vecs[i].burst, vecs[i].wdata, vecs[i].strb, 1, resp);
        chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, 8'd0, vecs[i].size, vecs[i].burst, 1'b0, n);
        chk($sformatf("vec%0d_beats", i), 32'(n), 32'd1);
        chk($sformatf("vec%0d_rresp", i), 32'(rrsp[0]), 32'(vecs[i].exp_resp));
        chk($sformatf("vec%0d_rdata", i), rdat[0], vecs[i].exp_rdata);
        chk($sformatf("vec%0d_rlast", i), 32'(rlst[0]), 32'd1);
      end
    end

    // 16-beat INCR write and readback.
    do_write(32'h4000_0000, 8'd15, 3'b010, 2'b01, 32'd0, 4'hF, 16, resp);
    chk("b16_bresp", 32'(resp), 32'd0);
    do_read(32'h4000_0000, 8'd15, 3'b010, 2'b01, 1'b0, n);
    for (int i = 0; i < 16; i++) exp[i] = 32'(i);
    check_burst("b16", n, 16, exp, 2'b00);

    // INCR burst wrapping from index 1022 to 0.
    do_write(32'h0000_0FF8, 8'd3, 3'b010, 2'b01, 32'hC0DE_0000, 4'hF, 4, resp);
    chk("wrap_bresp", 32'(resp), 32'd0);
    do_read(32'h0000_0FF8, 8'd3, 3'b010, 2'b01, 1'b0, n);
    for (int i = 0; i < 4; i++) exp[i] = 32'hC0DE_0000 + 32'(i);
    check_burst("wrap_rd", n, 4, exp, 2'b00);
    do_read(32'h0000_0000, 8'd1, 3'b010, 2'b01, 1'b0, n);
    exp[0] = 32'hC0DE_0002; exp[1] = 32'hC0DE_0003;
    check_burst("wrap_low", n, 2, exp, 2'b00);

    // WRAP burst type: all beats accepted, SLVERR, memory untouched.
    do_write(32'h0000_0000, 8'd3, 3'b010, 2'b10, 32'hDEAD_0000, 4'hF, 4, resp);
    chk("wrapbt_bresp", 32'(resp), 32'd2);
    do_read(32'h0000_0000, 8'd3, 3'b010, 2'b01, 1'b0, n);
    exp[0] = 32'hC0DE_0002; exp[1] = 32'hC0DE_0003; exp[2] = 32'd2; exp[3] = 32'd3;
    check_burst("wrapbt_rd", n, 4, exp, 2'b00);

    // 8-beat read with RREADY toggling, concurrent with a write burst.
    fork
      do_read(32'h0000_0000, 8'd7, 3'b010, 2'b01, 1'b1, n);
      do_write(32'h0000_0190, 8'd3, 3'b010, 2'b01, 32'hBEEF_0000, 4'hF, 4, resp2);
    join
    exp[0] = 32'hC0DE_0002; exp[1] = 32'hC0DE_0003;
    for (int i = 2; i < 8; i++) exp[i] = 32'(i);
    check_burst("stall_rd", n, 8, exp, 2'b00);
    chk("conc_bresp", 32'(resp2), 32'd0);
    do_read(32'h0000_0190, 8'd3, 3'b010, 2'b01, 1'b0, n);
    for (int i = 0; i < 4; i++) exp[i] = 32'hBEEF_0000 + 32'(i);
    check_burst("conc_rd", n, 4, exp, 2'b00);

    // Early WLAST: written beats stay, SLVERR.
    do_write(32'h0000_0320, 8'd3, 3'b010, 2'b01, 32'h1111_0000, 4'hF, 2, resp);
    chk("early_bresp", 32'(resp), 32'd2);
    do_read(32'h0000_0320, 8'd1, 3'b010, 2'b01, 1'b0, n);
    exp[0] = 32'h1111_0000; exp[1] = 32'h1111_0001;
    check_burst("early_rd", n, 2, exp, 2'b00);

    // Overrun: beats past LEN are dropped, SLVERR at WLAST.
    do_write(32'h0000_0350, 8'd0, 3'b010, 2'b01, 32'h5555_5555, 4'hF, 1, resp);
    chk("pre_bresp", 32'(resp), 32'd0);
    do_write(32'h0000_0348, 8'd1, 3'b010, 2'b01, 32'h2222_0000, 4'hF, 4, resp);
    chk("over_bresp", 32'(resp), 32'd2);
    do_read(32'h0000_0348, 8'd2, 3'b010, 2'b01, 1'b0, n);
    exp[0] = 32'h2222_0000; exp[1] = 32'h2222_0001; exp[2] = 32'h5555_5555;
    check_burst("over_rd", n, 3, exp, 2'b00);

    // FIXED burst: last beat wins, FIXED read repeats the word.
    do_write(32'h0000_04B0, 8'd3, 3'b010, 2'b00, 32'h3333_0000, 4'hF, 4, resp);
    chk("fixed_bresp", 32'(resp), 32'd0);
    do_read(32'h0000_04B0, 8'd1, 3'b010, 2'b00, 1'b0, n);
    exp[0] = 32'h3333_0003; exp[1] = 32'h3333_0003;
    check_burst("fixed_rd", n, 2, exp, 2'b00);

    // Reset pulsed during beat 3 of an 8-beat write.
    awaddr = 32'h0000_0600; awlen = 8'd7; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b1;
    while (!awready) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wdata = 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      while (!wready) begin @(posedge clk); #1; end
      @(posedge clk); #1;
    end
    arst_n = 1'b0;
    #1;
    wvalid = 1'b0;
    chk("mid_rst_ready", {30'd0, awready, arready}, 32'd0);
    chk("mid_rst_valid", {29'd0, wready, bvalid, rvalid}, 32'd0);
    chk("mid_rst_resp", {28'd0, bresp, rresp}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    @(posedge clk); #3;
    arst_n = 1'b1;
    #1 chk("mid_rel_pre", 32'(awready), 32'd0);
    @(posedge clk); #1;
    chk("mid_rel_awready", 32'(awready), 32'd1);
    n = 0;
    bready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bvalid) n++;
      @(posedge clk); #1;
    end
    bready = 1'b0;
    chk("mid_no_b", 32'(n), 32'd0);
    do_write(32'h0000_0600, 8'd0, 3'b010, 2'b01, 32'h7777_0000, 4'hF, 1, resp);
    chk("post_rst_bresp", 32'(resp), 32'd0);
    do_read(32'h0000_0600, 8'd0, 3'b010, 2'b01, 1'b0, n);
    exp[0] = 32'h7777_0000;
    check_burst("post_rst_rd", n, 1, exp, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_full_mem_slave.md
# axi_full_mem_slave

AXI4-Full memory responder backing the DMA's read master (M00) and write master (M01) in simulation and on-board loopback builds. It accepts INCR/FIXED bursts on independent read and write channels, stores data in an internal word-addressed register array, and returns OKAY or SLVERR responses. It gives the DMA a self-contained target, so source and destination regions live in one instance with no external memory controller.

## Interface
- C_S_AXI_ID_WIDTH, 1: ID width; IDs are echoed, never interpreted.
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 32: address width.
- C_MEM_DEPTH_LOG2, 10: memory depth is 2^N words. Word index = ADDR[N+1:2]; upper address bits are ignored (aliasing).
- S_AXI_ACLK  in  1  single clock; all logic is rising-edge.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID/ADDR/8/3/2  write address channel.
- S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA/WSTRB/WLAST/WVALID  in  32/4/1/1; S_AXI_WREADY  out  1.
- S_AXI_BID  out  ID; S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID/ADDR/8/3/2  read address channel.
- S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
- S_AXI_RID  out  ID; S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RLAST  out  1; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- The block has no LOCK, CACHE, PROT, QOS or USER ports. The integrating top ties these off.

## Operation
- Write FSM states and transitions:
  - W_IDLE: AWREADY=1. On an AW handshake, latch ID, index, LEN, BURST and error flag, clear the beat counter, then go to W_DATA.
  - W_DATA: WREADY=1. On each W handshake, write each byte lane whose WSTRB bit is set, unless the error flag is set. Then advance the index (INCR: +1; FIXED: hold) and increment the beat counter.
  - The handshake with WLAST=1 goes to W_RESP.
  - W_RESP: BVALID=1, BID=latched ID. Return to W_IDLE on BREADY.
- Read FSM states and transitions:
  - R_IDLE: ARREADY=1. On an AR handshake, latch the read fields and go to R_DATA.
  - R_DATA: RVALID=1, RDATA=mem[index] (0 when the error flag is set), RLAST=1 when beat count == LEN.
  - On each R handshake, advance as in the write FSM. The RLAST handshake returns to R_IDLE.
- Error flag is set when SIZE != 3'b010 or BURST == 2'b10 (WRAP) or BURST == 2'b11. Response is SLVERR (2'b10); otherwise OKAY.
- Write beat count mismatch:
  - WLAST on beat k < LEN: end the burst with SLVERR. Beats already written stay written.
  - Beat count > LEN without WLAST: no further writes. Keep accepting beats until WLAST, then SLVERR.
- Wrap-around: an INCR burst crossing index 2^N-1 continues at index 0.
- Read and write FSMs are fully independent. Same-cycle read and write to the same index: RDATA shows the old word that cycle and the new word from the next cycle.
- Each channel has one outstanding transaction; the other channel is not blocked.

## Timing
- All outputs are 0 while ARESETN=0. AWREADY and ARREADY rise on the first clock edge after reset release.
- Reset asserted mid-burst: both FSMs go to idle immediately. No B or R response is issued. Memory contents are undefined.
- AW/AR handshake at edge t: WREADY or RVALID is high from edge t+1.
- Read throughput: 1 beat/cycle with RREADY held high. An (ARLEN+1)-beat burst occupies ARLEN+2 cycles from AR handshake to RLAST handshake.
- Write throughput: 1 beat/cycle. BVALID rises the edge after the WLAST handshake.
- Once asserted, RVALID, RDATA, RLAST, RRESP and RID are held stable until the RREADY handshake. BVALID/BRESP/BID are held likewise until BREADY.
- Beat counter is 8 bits, compared against LEN, and never overflows (max 256 beats).

## Configuration
- AXI_MEM_STALL_EN defined: adds a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) that advances every cycle.
  - When lfsr[0]=1, WREADY is forced to 0.
  - When lfsr[0]=1, a new R beat is not presented. RVALID is never dropped once asserted.
  - Purpose: exercises DMA backpressure handling.
- AXI_MEM_STALL_EN undefined: the LFSR is absent and timing is exactly as stated above.

## Test plan
- Write AWADDR=0x40000000, AWLEN=15, data 0..15, WSTRB=4'hF; read back ARLEN=15 -> BRESP=OKAY; RDATA 0..15 in order; RLAST only on beat 16.
- Write 0xFFFFFFFF to index 5; then write 0x00000000 with WSTRB=4'b0101 -> read of index 5 returns 0xFF00FF00.
- INCR burst, AWLEN=3, starting at index 1022 (N=10) -> words land in indices 1022, 1023, 0, 1; readback matches.
- AWBURST=2'b10 (WRAP), AWLEN=3 -> 4 beats accepted, BRESP=2'b10, memory unchanged. ARSIZE=3'b001 read -> RRESP=2'b10, RDATA=0.
- RREADY toggled 1-0-1-0 during an 8-beat read -> RDATA/RLAST stable while stalled. Concurrent write burst completes unaffected.
- ARESETN pulsed low mid-write (beat 3 of 8) -> all outputs 0; AWREADY=1 one edge after release; no BVALID is issued.
